// File: rtl/fpu_frame_loader.sv
// Operand-assembly stage: collects a 5-byte strobed frame (A, B, opcode) from the pin bus
// and presents shadow-registered operands to the FPU with a one-cycle start pulse.
module fpu_frame_loader (
   input  logic        clock,
   input  logic        reset,
   input  logic [11:0] in,
   output logic [15:0] num1,
   output logic [15:0] num2,
   output logic [3:0]  op,
   output logic        start,
   output logic        busy,
   output logic        frame_err
);

   localparam int FRAME_BYTES = 5;

   logic [1:0]  s1_r;
   logic [1:0]  s2_r;
   logic        p_r;
   logic [2:0]  cnt_r;
   logic [2:0]  cnt_nxt_s;
   logic [15:0] stage_a_r;
   logic [15:0] stage_b_r;
   logic        byte_ev_s;
   logic        sof_s;
   logic [7:0]  data_s;
   logic        done_s;
   logic        err_s;

   assign byte_ev_s = s2_r[1] & ~p_r;
   assign sof_s     = s2_r[0];
   assign data_s    = in[7:0];

   // Synchronizer and strobe edge register; reset high so a held strobe gives no event.
   always_ff @(posedge clock) begin
      if (reset) begin
         s1_r <= 2'b11;
         s2_r <= 2'b11;
         p_r  <= 1'b1;
      end else begin
         s1_r <= in[11:10];
         s2_r <= s1_r;
         p_r  <= s2_r[1];
      end
   end

   // State register: byte counter, staging registers and registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_r     <= 3'd0;
         stage_a_r <= 16'h0000;
         stage_b_r <= 16'h0000;
         num1      <= 16'h0000;
         num2      <= 16'h0000;
         op        <= 4'h0;
         start     <= 1'b0;
         busy      <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         cnt_r     <= cnt_nxt_s;
         start     <= done_s;
         frame_err <= err_s;
         busy      <= (cnt_nxt_s != 3'd0);
         if (byte_ev_s) begin
            if (sof_s) begin
               stage_a_r[15:8] <= data_s;
            end else begin
               case (cnt_r)
                  3'd1:    stage_a_r[7:0]  <= data_s;
                  3'd2:    stage_b_r[15:8] <= data_s;
                  3'd3:    stage_b_r[7:0]  <= data_s;
                  default: stage_a_r       <= stage_a_r;
               endcase
            end
         end
         if (done_s) begin
            num1 <= stage_a_r;
            num2 <= stage_b_r;
            op   <= data_s[3:0];
         end
      end
   end

   // Next-state logic for the byte counter.
   always_comb begin
      cnt_nxt_s = cnt_r;
      if (byte_ev_s) begin
         if (sof_s) begin
            cnt_nxt_s = 3'd1;
         end else begin
            case (cnt_r)
               3'd0:    cnt_nxt_s = 3'd0;
               3'd1:    cnt_nxt_s = 3'd2;
               3'd2:    cnt_nxt_s = 3'd3;
               3'd3:    cnt_nxt_s = 3'd4;
               3'd4:    cnt_nxt_s = 3'd0;
               default: cnt_nxt_s = 3'd0;
            endcase
         end
      end else begin
         cnt_nxt_s = cnt_r;
      end
   end

   // Output decode: frame completion and protocol-violation pulses.
   always_comb begin
      done_s = 1'b0;
      err_s  = 1'b0;
      if (byte_ev_s) begin
         if (sof_s) begin
            err_s = (cnt_r != 3'd0);
         end else begin
            case (cnt_r)
               3'd0:    err_s  = 1'b1;
               3'(FRAME_BYTES - 1): done_s = 1'b1;
               default: done_s = 1'b0;
            endcase
         end
      end else begin
         done_s = 1'b0;
      end
   end

endmodule

// File: tb/tb_fpu_frame_loader.sv
// Scoreboard bench for fpu_frame_loader: completed frames are queued when sent and
// checked against num1/num2/op on each start pulse.
module tb_fpu_frame_loader;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [11:0] in = 12'h000;
   logic [15:0] num1;
   logic [15:0] num2;
   logic [3:0]  op;
   logic        start;
   logic        busy;
   logic        frame_err;

   int vectors = 0;
   int miscompares = 0;
   int start_cnt = 0;
   int err_cnt = 0;
   logic [35:0] exp_q[$];

   fpu_frame_loader dut (
      .clock(clock), .reset(reset), .in(in),
      .num1(num1), .num2(num2), .op(op),
      .start(start), .busy(busy), .frame_err(frame_err)
   );

   always #5 clock = ~clock;

   // Monitor: pop the scoreboard on every start pulse.
   always @(negedge clock) begin
      logic [35:0] e;
      if (!reset) begin
         if (start) start_cnt++;
         if (frame_err) err_cnt++;
         if (start && frame_err) begin
            vectors++; miscompares++;
            $display("FAIL start_and_err: both high at %0t", $time);
         end
         if (start) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_start: got %h/%h/%h, none expected", num1, num2, op);
            end else begin
               e = exp_q.pop_front();
               if ({num1, num2, op} !== e) begin
                  miscompares++;
                  $display("FAIL frame: got %h/%h/%h, expected %h/%h/%h",
                           num1, num2, op, e[35:20], e[19:4], e[3:0]);
               end
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic s, input int lo);
      in[10] = s; in[7:0] = d; in[11] = 1'b0;
      tick(1);
      in[11] = 1'b1;
      tick(3);
      in[11] = 1'b0;
      tick(lo);
   endtask

   task automatic send_frame(input logic [15:0] a, input logic [15:0] b,
                             input logic [7:0] o, input int lo);
      send_byte(a[15:8], 1'b1, lo);
      send_byte(a[7:0], 1'b0, lo);
      send_byte(b[15:8], 1'b0, lo);
      send_byte(b[7:0], 1'b0, lo);
      exp_q.push_back({a, b, o[3:0]});
      send_byte(o, 1'b0, lo);
   endtask

   task automatic test_reset;
      reset = 1'b1; in = 12'h000;
      tick(2);
      vectors++;
      if ({num1, num2, op, start, busy, frame_err} !== 39'd0) begin
         miscompares++;
         $display("FAIL reset: got %h/%h/%h s%b b%b e%b, expected all zero",
                  num1, num2, op, start, busy, frame_err);
      end
      reset = 1'b0;
      tick(4);
   endtask

   task automatic test_nominal;
      int s0 = start_cnt;
      logic [7:0] bytes [5] = '{8'h3C, 8'h00, 8'h40, 8'h00, 8'h05};
      for (int i = 0; i < 5; i++) begin
         if (i == 4) exp_q.push_back({16'h3C00, 16'h4000, 4'h5});
         send_byte(bytes[i], (i == 0), 3);
         vectors++;
         if (busy !== (i < 4)) begin
            miscompares++;
            $display("FAIL nominal_busy%0d: got %b, expected %b", i, busy, (i < 4));
         end
      end
      vectors++;
      if (start_cnt - s0 != 1) begin
         miscompares++;
         $display("FAIL nominal_starts: got %0d, expected 1", start_cnt - s0);
      end
   endtask

   task automatic test_outputs_stable;
      int s0 = start_cnt;
      send_byte(8'h77, 1'b1, 3);
      send_byte(8'h88, 1'b0, 3);
      send_byte(8'h99, 1'b0, 3);
      vectors++;
      if ({num1, num2, op, busy} !== {16'h3C00, 16'h4000, 4'h5, 1'b1} || start_cnt != s0) begin
         miscompares++;
         $display("FAIL stable: got %h/%h/%h busy%b starts%0d, expected 3c00/4000/5 busy1 starts0",
                  num1, num2, op, busy, start_cnt - s0);
      end
   endtask

   task automatic test_resync;
      int s0 = start_cnt;
      int e0 = err_cnt;
      send_byte(8'hC0, 1'b1, 3);
      vectors++;
      if (err_cnt - e0 != 1) begin
         miscompares++;
         $display("FAIL resync_err: got %0d pulses, expected 1", err_cnt - e0);
      end
      send_byte(8'h00, 1'b0, 3);
      send_byte(8'h3C, 1'b0, 3);
      send_byte(8'h00, 1'b0, 3);
      exp_q.push_back({16'hC000, 16'h3C00, 4'h1});
      send_byte(8'h01, 1'b0, 3);
      vectors++;
      if (start_cnt - s0 != 1 || err_cnt - e0 != 1) begin
         miscompares++;
         $display("FAIL resync_counts: got starts %0d errs %0d, expected 1 and 1",
                  start_cnt - s0, err_cnt - e0);
      end
   endtask

   task automatic test_stray;
      int e0 = err_cnt;
      send_byte(8'h7F, 1'b0, 3);
      vectors++;
      if (err_cnt - e0 != 1 || busy !== 1'b0 ||
          {num1, num2, op} !== {16'hC000, 16'h3C00, 4'h1}) begin
         miscompares++;
         $display("FAIL stray: got errs %0d busy%b %h/%h/%h, expected 1 busy0 c000/3c00/1",
                  err_cnt - e0, busy, num1, num2, op);
      end
      send_frame(16'h1111, 16'h2222, 8'hF3, 3);
      vectors++;
      if (op !== 4'h3) begin
         miscompares++;
         $display("FAIL stray_op: got %h, expected 3", op);
      end
   endtask

   task automatic test_back_to_back;
      int s0 = start_cnt;
      int e0 = err_cnt;
      send_frame(16'hABCD, 16'h1234, 8'h09, 1);
      send_frame(16'h8001, 16'h7FFE, 8'h5E, 1);
      vectors++;
      if (start_cnt - s0 != 2 || err_cnt != e0) begin
         miscompares++;
         $display("FAIL b2b_counts: got starts %0d errs %0d, expected 2 and 0",
                  start_cnt - s0, err_cnt - e0);
      end
   endtask

   task automatic test_reset_mid;
      int s0 = start_cnt;
      int e0 = err_cnt;
      send_byte(8'h12, 1'b1, 3);
      send_byte(8'h34, 1'b0, 3);
      in[10] = 1'b1; in[7:0] = 8'hAA; in[11] = 1'b1;
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      tick(4);
      in[11] = 1'b0;
      tick(3);
      vectors++;
      if (busy !== 1'b0 || {num1, num2, op} !== 36'd0 || err_cnt != e0 || start_cnt != s0) begin
         miscompares++;
         $display("FAIL reset_mid: got busy%b %h/%h/%h errs %0d starts %0d, expected all zero",
                  busy, num1, num2, op, err_cnt - e0, start_cnt - s0);
      end
      send_frame(16'h1234, 16'h5678, 8'h9A, 3);
      vectors++;
      if ({num1, num2, op, busy} !== {16'h1234, 16'h5678, 4'hA, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_mid_frame: got %h/%h/%h busy%b, expected 1234/5678/a busy0",
                  num1, num2, op, busy);
      end
   endtask

   initial begin
      test_reset;
      test_nominal;
      test_outputs_stable;
      test_resync;
      test_stray;
      test_back_to_back;
      test_reset_mid;
      tick(3);
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL leftover: got %0d frames pending, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
